// File: rtl/bcd_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_if
// Bundle between a display controller (master) and bcd_scan_control (slave).
//   value_in    : packed digit codes, nibble i = position i (0 = rightmost)
//   dp_in       : decimal-point request per position, 1 = lit
//   load        : one-cycle strobe capturing value_in/dp_in
//   load_ack    : one-cycle pulse the cycle after load
//   blank_lz    : 1 = blank leading zero positions
//   enable      : 0 = display dark
//   digit       : 4-bit code of the active position, to the cathode decoder
//   anode       : active-low one-hot position select
//   dp          : active-low decimal point of the active position
//   frame_start : one-cycle pulse when the outputs switch to position 0
// ---------------------------------------------------------------------------
interface bcd_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    load_ack;
  logic                    blank_lz;
  logic                    enable;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output value_in, dp_in, load, blank_lz, enable,
    input  load_ack, digit, anode, dp, frame_start
  );

  modport slave (
    input  value_in, dp_in, load, blank_lz, enable,
    output load_ack, digit, anode, dp, frame_start
  );
endinterface

// File: rtl/bcd_scan_control.sv
// ---------------------------------------------------------------------------
// bcd_scan_control
// Time-multiplexes a packed hex/BCD value across an active-low anode bank.
// A free-running refresh counter divides clk into digit slots; each slot
// presents one digit code, a one-hot-low anode and an active-low decimal
// point. New values are loaded into a pending buffer and copied into the
// displayed (active) buffer only at a frame boundary, so a frame never tears.
//
// Ports
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : bcd_scan_if.slave (load/ack handshake, controls, display drive)
// ---------------------------------------------------------------------------
module bcd_scan_control #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  bcd_scan_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_index;
  logic                    r_started;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;

  // Registered outputs
  logic [3:0]              r_digit;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic                    r_dp;
  logic                    r_load_ack;
  logic                    r_frame_start;

  // Next-slot values, used only on a tick
  logic                    w_tick;
  logic [IDX_W-1:0]        w_next_index;
  logic                    w_boundary;
  logic [4*NUM_DIGITS-1:0] w_next_val;
  logic [NUM_DIGITS-1:0]   w_next_dp;
  logic [NUM_DIGITS-1:0]   w_zero_from;
  logic [3:0]              w_nib;
  logic                    w_sel_dp;
  logic                    w_lead_zero;
  logic                    w_blank;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_anode_sel;

  assign w_tick = (r_cnt == CNT_LAST);

  // The first tick after reset opens a frame at position 0 rather than
  // stepping to position 1, so scanning always restarts at index 0.
  assign w_next_index = (!r_started || r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
  assign w_boundary   = w_tick && (w_next_index == '0);

  // Active buffer as it stands after this tick's transfer; the slot being
  // opened must already show it.
  assign w_next_val = (w_boundary && r_pend_valid) ? r_pend_val : r_act_val;
  assign w_next_dp  = (w_boundary && r_pend_valid) ? r_pend_dp  : r_act_dp;

  always_comb begin
    logic zero_run;
    // NOTE: every always_comb variable gets a default before any branch or loop, so no latch can be inferred.
    w_zero_from = '0;
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_lead_zero = 1'b0;
    zero_run    = 1'b1;
    // w_zero_from[i] = 1 when nibbles i..NUM_DIGITS-1 are all zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run       = zero_run & (w_next_val[4*i +: 4] == 4'h0);
      w_zero_from[i] = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_next_index == IDX_W'(i)) begin
        w_nib       = w_next_val[4*i +: 4];
        w_sel_dp    = w_next_dp[i];
        w_lead_zero = (i > 0) && w_zero_from[i];
      end
    end
  end

  assign w_blank     = bus.blank_lz & w_lead_zero;
  assign w_dark      = w_blank | ~bus.enable;
  assign w_anode_sel = ~(NUM_DIGITS'(1) << w_next_index);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the buffers are a handful of flops, not a RAM, so they are cleared here like any other state.
      r_cnt         <= '0;
      r_index       <= '0;
      r_started     <= 1'b0;
      r_pend_val    <= '0;
      r_pend_dp     <= '0;
      r_pend_valid  <= 1'b0;
      r_act_val     <= '0;
      r_act_dp      <= '0;
      r_digit       <= 4'h0;
      r_anode       <= '1;
      r_dp          <= 1'b1;
      r_load_ack    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop see the pre-edge values, independent of statement order.
      r_load_ack    <= bus.load;
      r_frame_start <= 1'b0;

      if (w_tick) begin
        r_cnt         <= '0;
        r_index       <= w_next_index;
        r_started     <= 1'b1;
        r_act_val     <= w_next_val;
        r_act_dp      <= w_next_dp;
        r_digit       <= w_blank ? 4'h0 : w_nib;
        r_anode       <= w_dark ? '1 : w_anode_sel;
        r_dp          <= w_dark ? 1'b1 : ~w_sel_dp;
        r_frame_start <= w_boundary;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // A load on the boundary lands after the transfer above has taken the
      // old pending contents, and keeps the flag set for the next frame.
      if (bus.load) begin
        r_pend_val   <= bus.value_in;
        r_pend_dp    <= bus.dp_in;
        r_pend_valid <= 1'b1;
      end else if (w_boundary) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign bus.digit       = r_digit;
  assign bus.anode       = r_anode;
  assign bus.dp          = r_dp;
  assign bus.load_ack    = r_load_ack;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/bcd_scan_control.md
Name: bcd_scan_control

Overview:
- Upstream stage of the seven-segment datapath; time-multiplexes a packed hex/BCD value across an active-low anode bank.
- Each refresh slot presents one 4-bit digit code to the downstream digit-to-cathode decoder, plus a matching one-hot-low anode and an active-low decimal point.
- Double-buffered load prevents mid-frame tearing.
- Optional leading-zero blanking.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digit positions (legal range 2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives a 1 kHz slot rate); minimum 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- value_in  input  4*NUM_DIGITS  packed digit codes; nibble i = position i; position 0 = rightmost
- dp_in  input  NUM_DIGITS  decimal-point request per position, 1 = lit
- load  input  1  one-cycle strobe; captures value_in/dp_in into the pending buffer
- load_ack  output  1  one-cycle pulse, the cycle after load
- blank_lz  input  1  1 = blank leading zero positions
- enable  input  1  0 = display dark
- digit  output  4  code for the active position, to the cathode decoder
- anode  output  NUM_DIGITS  active-low position select
- dp  output  1  active-low decimal point for the active position
- frame_start  output  1  one-cycle pulse when outputs switch to position 0

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - refresh counter = 0, index = 0
  - pending/active value = 0, pending/active dp = 0, pending flag = 0
  - digit = 0, anode = all 1s, dp = 1, load_ack = 0, frame_start = 0
- Reset asserted mid-frame or mid-load discards all state. After release, scanning restarts at index 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (counter == REFRESH_DIV-1).
  - On tick, index advances by 1 and wraps from NUM_DIGITS-1 to 0.
  - The counter and index run regardless of enable.
- Frame boundary is the tick on which index wraps to 0. On it:
  - If the pending flag is 1, active <= pending and the pending flag clears.
  - Otherwise active is unchanged.
- Load:
  - On load, pending <= {value_in, dp_in} and the pending flag is set.
  - load_ack = 1 in the next cycle.
  - Repeated loads before a boundary: last one wins.
  - Load coincident with a boundary: the boundary transfers the prior pending contents, the new data lands in pending, and it applies at the following boundary.
- Outputs are registered and update in the cycle after tick, using the new index and the active buffer as it stands after that tick's transfer. Digit 0 of a new frame therefore already shows the new value.
  - digit = active nibble[index]
  - anode = all 1s except bit[index] = 0
  - dp = ~active_dp[index]
- frame_start = 1 in the same cycle the outputs first show index 0.
- Leading-zero blanking (blank_lz = 1): position i > 0 is blanked when active nibbles i..NUM_DIGITS-1 are all zero.
  - Position 0 is never blanked.
  - Blanked slot: anode all 1s, dp = 1, digit = 0.
  - blank_lz is sampled at each slot update.
- enable = 0: in the next output update cycle, anode = all 1s and dp = 1. digit keeps tracking index. enable = 1 resumes output at the next tick.
- Width rules: refresh counter width = clog2(REFRESH_DIV); index width = clog2(NUM_DIGITS).

Test Plan:
- Scan and boundary load (NUM_DIGITS=4, REFRESH_DIV=4): reset, load value 0x1234, dp_in 0 -> frame after the boundary shows digit 4,3,2,1 with anode 1110,1101,1011,0111, each held 4 cycles; frame_start pulses once per 16 cycles; load_ack pulses 1 cycle after load.
- Leading-zero blanking: load 0x0050 with blank_lz=1 -> positions 0 and 1 lit (digit 0, 5); positions 2 and 3 have anode 1111. Load 0x0000 -> only position 0 lit, showing 0.
- Mid-frame load: load 0xAAAA during slot 2, then 0xBBBB during slot 3 -> rest of current frame still shows the old value; next frame shows B on all positions.
- Load coincident with the boundary tick while pending holds 0x1111: load 0x2222 -> next frame 1111, frame after 2222.
- Decimal point and enable: dp_in 0b0100 -> dp = 0 only while anode = 1011. enable low -> anode 1111 and dp = 1 from the next output update; re-enable -> display resumes at the next tick.
- Async reset mid-slot: assert reset_n low between clk edges -> anode 1111, dp 1, digit 0 immediately; after release the first slot is index 0 after REFRESH_DIV cycles, showing value 0.
